obi_wb_bridge: RTL

- Sits directly downstream of the cv32e41p core, between its two OBI master ports (instruction fetch and data load/store) and the single Wishbone classic master port consumed by the Controller (core_cyc/stb/we/addr/data).
- Arbitrates the two OBI requesters round-robin and keeps exactly one transaction outstanding.
- Converts OBI req/gnt/rvalid into Wishbone cyc/stb/ack.
- Provides a bus timeout that terminates hung transactions with an error response.

---
 rtl/obi_wb_bridge.sv | 95 +++++++++
 1 files changed

// File: rtl/obi_wb_bridge.sv
// obi_wb_bridge: round-robin arbiter joining two OBI ports onto one Wishbone classic master with a bus timeout
module obi_wb_bridge #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  instr_req_i,
    output logic                  instr_gnt_o,
    output logic                  instr_rvalid_o,
    input  logic [ADDR_WIDTH-1:0] instr_addr_i,
    output logic [DATA_WIDTH-1:0] instr_rdata_o,
    output logic                  instr_err_o,
    input  logic                  data_req_i,
    output logic                  data_gnt_o,
    output logic                  data_rvalid_o,
    input  logic                  data_we_i,
    input  logic [3:0]            data_be_i,
    input  logic [ADDR_WIDTH-1:0] data_addr_i,
    input  logic [DATA_WIDTH-1:0] data_wdata_i,
    output logic [DATA_WIDTH-1:0] data_rdata_o,
    output logic                  data_err_o,
    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    output logic                  wb_we_o,
    output logic [3:0]            wb_sel_o,
    output logic [ADDR_WIDTH-1:0] wb_addr_o,
    output logic [DATA_WIDTH-1:0] wb_data_o,
    input  logic [DATA_WIDTH-1:0] wb_data_i,
    input  logic                  wb_ack_i
);
    typedef enum logic {IDLE, WB_BUSY} state_t;
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);
    state_t state;
    logic rr_last;
    logic [31:0] cnt;
    logic idle, pick_data, timeout;
    logic [DATA_WIDTH-1:0] resp;
    assign idle = state == IDLE && !rst;
    assign pick_data = data_req_i && (!instr_req_i || !rr_last);
    assign data_gnt_o = idle && pick_data;
    assign instr_gnt_o = idle && instr_req_i && !pick_data;
    assign timeout = TIMEOUT_CYCLES != 0 && cnt == TO_LAST;
    assign resp = wb_we_o ? '0 : (wb_ack_i ? wb_data_i : ERR_DATA);
    assign wb_cyc_o = state == WB_BUSY;
    assign wb_stb_o = state == WB_BUSY;
    // grant and latch a request, then hold the bus until ack or timeout; rr_last doubles as the owner
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            rr_last <= 1'b0;
            cnt <= '0;
            wb_we_o <= 1'b0;
            wb_sel_o <= '0;
            wb_addr_o <= '0;
            wb_data_o <= '0;
            instr_rvalid_o <= 1'b0;
            instr_rdata_o <= '0;
            instr_err_o <= 1'b0;
            data_rvalid_o <= 1'b0;
            data_rdata_o <= '0;
            data_err_o <= 1'b0;
        end else begin
            instr_rvalid_o <= 1'b0;
            data_rvalid_o <= 1'b0;
            if (state == IDLE) begin
                if (instr_gnt_o || data_gnt_o) begin
                    state <= WB_BUSY;
                    rr_last <= data_gnt_o;
                    cnt <= '0;
                    wb_addr_o <= data_gnt_o ? data_addr_i : instr_addr_i;
                    wb_we_o <= data_gnt_o && data_we_i;
                    wb_sel_o <= data_gnt_o ? data_be_i : 4'hF;
                    wb_data_o <= data_gnt_o ? data_wdata_i : '0;
                end
            end else if (wb_ack_i || timeout) begin
                state <= IDLE;
                cnt <= '0;
                if (rr_last) begin
                    data_rvalid_o <= 1'b1;
                    data_rdata_o <= resp;
                    data_err_o <= !wb_ack_i;
                end else begin
                    instr_rvalid_o <= 1'b1;
                    instr_rdata_o <= resp;
                    instr_err_o <= !wb_ack_i;
                end
            end else begin
                cnt <= cnt + 32'd1;
            end
        end
    end
endmodule
